// File: rtl/rx_serial_7e1_pkg.sv
// Shared constants for the 7E1 serial receiver: FSM state codes, bit timing defaults
// and frame length.
package rx_serial_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT   = 9600;
    localparam int DIV_DEFAULT    = CLK_HZ_DEFAULT / BAUD_DEFAULT;
    localparam int HALF_DEFAULT   = DIV_DEFAULT / 2;

    localparam int DATA_BITS = 7;
    localparam int CNT_W     = 13;

    localparam logic [3:0] ST_INICIAL      = 4'd0;
    localparam logic [3:0] ST_ESPERA_START = 4'd1;
    localparam logic [3:0] ST_DADOS        = 4'd2;
    localparam logic [3:0] ST_PARIDADE     = 4'd3;
    localparam logic [3:0] ST_STOP         = 4'd4;
    localparam logic [3:0] ST_ARMAZENA     = 4'd5;
    localparam logic [3:0] ST_ESPERA_IDLE  = 4'd6;

endpackage

// File: rtl/rx_serial_7e1_contador.sv
// Loadable bit-timing down-counter with expiry pulse and line sampler.
// With RX_MAJORITY_VOTE_EN defined, the sampled bit is a 2-of-3 vote at expiry-16/-8/0.
module contador_m
    import rx_serial_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             din_i,
    output logic             tick_o,
    output logic             bit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state is only ever assigned with non-blocking <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = en_i && (count_q == '0);

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] TAP_A = CNT_W'(16);
    localparam logic [CNT_W-1:0] TAP_B = CNT_W'(8);

    logic vote_a_q, vote_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_a_q <= 1'b1;
            vote_b_q <= 1'b1;
        end else begin
            if (en_i && (count_q == TAP_A)) vote_a_q <= din_i;
            if (en_i && (count_q == TAP_B)) vote_b_q <= din_i;
        end
    end

    assign bit_o = (vote_a_q & vote_b_q) | (vote_a_q & din_i) | (vote_b_q & din_i);
`else
    assign bit_o = din_i;
`endif

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver with tem_dado/recebe_dado handshake.
// Optional RX_MAJORITY_VOTE_EN selects 3-sample majority voting in contador_m.
module rx_serial_7e1
    import rx_serial_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int BAUD   = BAUD_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dado_serial,
    input  logic                 recebe_dado,
    output logic [DATA_BITS-1:0] dados_ascii,
    output logic                 tem_dado,
    output logic                 pronto,
    output logic                 erro_paridade,
    output logic                 erro_framing,
    output logic                 db_tick,
    output logic                 db_dado_serial,
    output logic [3:0]           db_estado
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    // The counter fires one cycle after reaching zero, and the start edge reaches the FSM
    // one cycle after s falls; the load values absorb both so samples land on HALF + k*DIV.
    localparam logic [CNT_W-1:0] LOAD_START = CNT_W'(HALF - 2);
    localparam logic [CNT_W-1:0] LOAD_BIT   = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    logic sync1_q, s_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            s_q     <= 1'b1;
        end else begin
            sync1_q <= dado_serial;
            s_q     <= sync1_q;
        end
    end

    logic [3:0]           state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d, stop_q, stop_d;
    logic                 cnt_load, cnt_en, tick, bit_smp, store;
    logic [CNT_W-1:0]     cnt_val;

    assign cnt_en = (state_q == ST_ESPERA_START) || (state_q == ST_DADOS) ||
                    (state_q == ST_PARIDADE)     || (state_q == ST_STOP);

    contador_m u_contador (
        .clk        (clock),
        .rst_n      (reset),
        .en_i       (cnt_en),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .din_i      (s_q),
        .tick_o     (tick),
        .bit_o      (bit_smp)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        stop_d   = stop_q;
        cnt_load = 1'b0;
        cnt_val  = LOAD_BIT;
        store    = 1'b0;
        case (state_q)
            ST_INICIAL: begin
                if (!s_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_START;
                    state_d  = ST_ESPERA_START;
                end
            end
            ST_ESPERA_START: begin
                if (tick) begin
                    if (bit_smp) begin
                        state_d = ST_INICIAL;
                    end else begin
                        cnt_load = 1'b1;
                        idx_d    = '0;
                        state_d  = ST_DADOS;
                    end
                end
            end
            ST_DADOS: begin
                if (tick) begin
                    shift_d  = {bit_smp, shift_q[DATA_BITS-1:1]};
                    cnt_load = 1'b1;
                    if (idx_q == LAST_BIT) state_d = ST_PARIDADE;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_PARIDADE: begin
                if (tick) begin
                    par_d    = bit_smp;
                    cnt_load = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    stop_d  = bit_smp;
                    state_d = ST_ARMAZENA;
                end
            end
            ST_ARMAZENA: begin
                store   = 1'b1;
                state_d = stop_q ? ST_INICIAL : ST_ESPERA_IDLE;
            end
            ST_ESPERA_IDLE: begin
                if (s_q) state_d = ST_INICIAL;
            end
            default: state_d = ST_INICIAL;
        endcase
    end

    logic [DATA_BITS-1:0] dados_q;
    logic                 tem_q, pronto_q, erro_par_q, erro_frm_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INICIAL;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_q     <= 1'b0;
            dados_q    <= '0;
            tem_q      <= 1'b0;
            pronto_q   <= 1'b0;
            erro_par_q <= 1'b0;
            erro_frm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            pronto_q <= store;
            if (store) begin
                dados_q    <= shift_q;
                erro_par_q <= (^shift_q) ^ par_q;
                erro_frm_q <= ~stop_q;
            end
            // A completing frame takes priority over a same-cycle acknowledge.
            if (store)            tem_q <= 1'b1;
            else if (recebe_dado) tem_q <= 1'b0;
        end
    end

    assign dados_ascii    = dados_q;
    assign tem_dado       = tem_q;
    assign pronto         = pronto_q;
    assign erro_paridade  = erro_par_q;
    assign erro_framing   = erro_frm_q;
    assign db_tick        = tick;
    assign db_dado_serial = s_q;
    assign db_estado      = state_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed self-checking bench for rx_serial_7e1, run at a scaled-down bit period
// (DIV = 128) so every scenario fits in a short simulation.
module tb_rx_serial_7e1;

    localparam int CLK_HZ  = 1_228_800;
    localparam int BAUD    = 9600;
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int HALF    = DIV / 2;
    localparam int LATENCY = 2 + HALF + 9 * DIV + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dado_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       tem_dado, pronto, erro_paridade, erro_framing;
    logic       db_tick, db_dado_serial;
    logic [3:0] db_estado;

    rx_serial_7e1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock          (clock),
        .reset          (reset),
        .dado_serial    (dado_serial),
        .recebe_dado    (recebe_dado),
        .dados_ascii    (dados_ascii),
        .tem_dado       (tem_dado),
        .pronto         (pronto),
        .erro_paridade  (erro_paridade),
        .erro_framing   (erro_framing),
        .db_tick        (db_tick),
        .db_dado_serial (db_dado_serial),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc = 0;
    longint fall_cyc = 0;
    longint last_pronto_cyc = 0;
    int     pronto_cnt = 0;
    logic   tem_at_pronto = 1'b0;
    int     p_before;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto) begin
            pronto_cnt++;
            last_pronto_cyc = cyc;
            tem_at_pronto   = tem_dado;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n_clk);
        dado_serial = v;
        repeat (n_clk) @(posedge clock);
        #1;
    endtask

    // Leaves the line at the stop value; the caller decides when to return it high.
    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                              input int stop_clks);
        fall_cyc = cyc;
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 7; i++) drive_bit(d[i], DIV);
        drive_bit(par, DIV);
        drive_bit(stp, stop_clks);
    endtask

    task automatic idle(input int n_clk);
        dado_serial = 1'b1;
        repeat (n_clk) @(posedge clock);
        #1;
    endtask

    task automatic ack();
        recebe_dado = 1'b1;
        @(posedge clock);
        #1;
        recebe_dado = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_dados", 32'(dados_ascii), 32'h00);
        check("rst_tem", 32'(tem_dado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_erro_par", 32'(erro_paridade), 32'd0);
        check("rst_erro_frm", 32'(erro_framing), 32'd0);
        check("rst_tick", 32'(db_tick), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_sync", 32'(db_dado_serial), 32'd1);
        reset = 1'b1;
        idle(20);

        // 35h, good parity and stop, with latency measurement
        p_before = pronto_cnt;
        send_frame(7'h35, 1'b0, 1'b1, DIV);
        idle(DIV);
        check("35_latency", 32'(last_pronto_cyc - fall_cyc), 32'(LATENCY));
        check("35_dados", 32'(dados_ascii), 32'h35);
        check("35_erro_par", 32'(erro_paridade), 32'd0);
        check("35_erro_frm", 32'(erro_framing), 32'd0);
        check("35_tem", 32'(tem_dado), 32'd1);
        check("35_pronto_cnt", 32'(pronto_cnt - p_before), 32'd1);
        ack();
        check("35_ack_tem", 32'(tem_dado), 32'd0);

        // 7Fh with wrong parity bit
        send_frame(7'h7F, 1'b0, 1'b1, DIV);
        idle(DIV);
        check("7f_dados", 32'(dados_ascii), 32'h7F);
        check("7f_erro_par", 32'(erro_paridade), 32'd1);
        check("7f_erro_frm", 32'(erro_framing), 32'd0);

        // 55h with stop bit low and the line held low for two bit times
        p_before = pronto_cnt;
        send_frame(7'h55, 1'b0, 1'b0, 2 * DIV);
        check("55brk_estado", 32'(db_estado), 32'd6);
        check("55brk_erro_frm", 32'(erro_framing), 32'd1);
        check("55brk_erro_par", 32'(erro_paridade), 32'd0);
        check("55brk_dados", 32'(dados_ascii), 32'h55);
        check("55brk_pronto_cnt", 32'(pronto_cnt - p_before), 32'd1);
        idle(4);
        check("55brk_estado_idle", 32'(db_estado), 32'd0);
        idle(2 * DIV);
        check("55brk_pronto_cnt2", 32'(pronto_cnt - p_before), 32'd1);

        // short low glitch on the idle line
        p_before = pronto_cnt;
        drive_bit(1'b0, 10);
        check("glitch_estado_mid", 32'(db_estado), 32'd1);
        drive_bit(1'b0, 20);
        idle(2 * DIV);
        check("glitch_estado", 32'(db_estado), 32'd0);
        check("glitch_pronto_cnt", 32'(pronto_cnt - p_before), 32'd0);
        check("glitch_tem", 32'(tem_dado), 32'd1);
        check("glitch_dados", 32'(dados_ascii), 32'h55);

        // 7Eh then acknowledge
        ack();
        send_frame(7'h7E, 1'b0, 1'b1, DIV);
        idle(DIV);
        check("7e_dados", 32'(dados_ascii), 32'h7E);
        check("7e_erro_par", 32'(erro_paridade), 32'd0);
        check("7e_tem", 32'(tem_dado), 32'd1);
        ack();
        check("7e_ack_tem", 32'(tem_dado), 32'd0);
        check("7e_dados_kept", 32'(dados_ascii), 32'h7E);

        // 2Ah with acknowledge held through completion: set wins, then clears
        recebe_dado = 1'b1;
        send_frame(7'h2A, 1'b1, 1'b1, DIV);
        idle(DIV);
        check("2a_tem_at_pronto", 32'(tem_at_pronto), 32'd1);
        check("2a_tem_after", 32'(tem_dado), 32'd0);
        recebe_dado = 1'b0;
        check("2a_dados", 32'(dados_ascii), 32'h2A);
        check("2a_erro_par", 32'(erro_paridade), 32'd0);

        // back-to-back 35h and 55h with no acknowledge
        p_before = pronto_cnt;
        send_frame(7'h35, 1'b0, 1'b1, DIV);
        idle(DIV);
        send_frame(7'h55, 1'b0, 1'b1, DIV);
        idle(DIV);
        check("b2b_dados", 32'(dados_ascii), 32'h55);
        check("b2b_tem", 32'(tem_dado), 32'd1);
        check("b2b_pronto_cnt", 32'(pronto_cnt - p_before), 32'd2);

        // reset during the 4th data bit
        p_before = pronto_cnt;
        fork
            send_frame(7'h55, 1'b0, 1'b1, DIV);
            begin
                repeat (4 * DIV + DIV / 2) @(posedge clock);
                #2 reset = 1'b0;
                #1;
                check("midrst_dados", 32'(dados_ascii), 32'h00);
                check("midrst_tem", 32'(tem_dado), 32'd0);
                check("midrst_pronto", 32'(pronto), 32'd0);
                check("midrst_erro_par", 32'(erro_paridade), 32'd0);
                check("midrst_erro_frm", 32'(erro_framing), 32'd0);
                check("midrst_tick", 32'(db_tick), 32'd0);
                check("midrst_estado", 32'(db_estado), 32'd0);
                check("midrst_sync", 32'(db_dado_serial), 32'd1);
            end
        join
        idle(5);
        reset = 1'b1;
        idle(2 * DIV);
        check("midrst_no_pronto", 32'(pronto_cnt - p_before), 32'd0);
        send_frame(7'h55, 1'b0, 1'b1, DIV);
        idle(DIV);
        check("post_rst_latency", 32'(last_pronto_cyc - fall_cyc), 32'(LATENCY));
        check("post_rst_dados", 32'(dados_ascii), 32'h55);
        check("post_rst_erro_par", 32'(erro_paridade), 32'd0);
        check("post_rst_erro_frm", 32'(erro_framing), 32'd0);
        check("post_rst_tem", 32'(tem_dado), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7E1

Asynchronous serial receiver for 7E1 frames at 9600 baud from a 50 MHz clock: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit. It is the receive counterpart of `tx_serial_7E1`. It recovers ASCII characters from the serial line, checks parity and framing, and holds each character behind a simple `tem_dado`/`recebe_dado` handshake for the consuming logic.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 9600: line rate.
- `DIV`, CLK_HZ/BAUD = 5208: clocks per bit (integer division, truncated).
- `HALF`, DIV/2 = 2604: clocks from start-edge detection to mid-start sample.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (`0` = reset); clears all state immediately.
- `dado_serial`  in  1  serial line; idle high; asynchronous to `clock`.
- `recebe_dado`  in  1  consumer acknowledge; clears `tem_dado`.
- `dados_ascii`  out  7  last received character.
- `tem_dado`  out  1  character available and not yet acknowledged.
- `pronto`  out  1  one-cycle pulse at frame completion.
- `erro_paridade`  out  1  parity error flag for `dados_ascii`.
- `erro_framing`  out  1  stop bit was sampled `0` for `dados_ascii`.
- `db_tick`  out  1  one-cycle pulse at every sample point.
- `db_dado_serial`  out  1  synchronized serial input.
- `db_estado`  out  4  current FSM state code.

## Operation
- `dado_serial` passes through a 2-FF synchronizer; all logic uses the synchronized value `s`.
- FSM states and codes:
  - `INICIAL` 0
  - `ESPERA_START` 1
  - `DADOS` 2
  - `PARIDADE` 3
  - `STOP` 4
  - `ARMAZENA` 5
  - `ESPERA_IDLE` 6
- `INICIAL`: on `s`=0, load counter with `HALF` and go to `ESPERA_START`.
- `ESPERA_START`: at counter expiry, sample `s`.
  - `s`=1 (glitch): return to `INICIAL`. No outputs change.
  - `s`=0: load `DIV`, set bit index 0, go to `DADOS`.
- `DADOS`: at each expiry, shift `s` into the data shift register at the LSB-first position, then reload `DIV`. After the 7th bit, go to `PARIDADE`.
- `PARIDADE`: at expiry, capture the parity bit and go to `STOP`.
- `STOP`: at expiry, capture the stop bit and go to `ARMAZENA`.
- `ARMAZENA` (one cycle):
  - Update `dados_ascii`.
  - `erro_paridade` = XOR of the 7 data bits and the parity bit (1 = error).
  - `erro_framing` = NOT stop bit.
  - Set `tem_dado` and pulse `pronto`.
  - Then go to `INICIAL` if the stop bit was 1, else `ESPERA_IDLE`.
- `ESPERA_IDLE`: remain until `s`=1, then go to `INICIAL`. This keeps a break condition from being received as repeated frames.
- Handshake:
  - `recebe_dado`=1 clears `tem_dado` on the next edge.
  - If `ARMAZENA` and `recebe_dado` occur in the same cycle, set wins.
  - A new frame completing while `tem_dado`=1 overwrites data and flags; `tem_dado` stays 1.

## Timing
- Reset values:
  - `dados_ascii`=0, `tem_dado`=0, `pronto`=0
  - `erro_paridade`=0, `erro_framing`=0
  - `db_tick`=0, `db_estado`=0
  - synchronizer FFs=1
- Reset mid-frame aborts the frame; no `pronto` is produced.
- Sample points, measured from the first clock edge with `s`=0:
  - start: `HALF` clocks
  - data bit k (k = 0..6): `HALF` + (k+1)·`DIV`
  - parity: `HALF` + 8·`DIV`
  - stop: `HALF` + 9·`DIV` = 49476
- `pronto` fires 1 cycle after the stop sample, i.e. 2+49476+1 = 49479 clocks after the falling line edge at the pin.
- Outputs are registered and update in the same cycle `pronto` is high.
- The counter is 13 bits and counts down to 0. `db_tick` is high in the expiry cycle.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined: each sample point takes 3 samples of `s`, at expiry−16, expiry−8 and expiry, and the bit value is the 2-of-3 majority. This applies to start, data, parity and stop.
- Undefined: a single sample at expiry.
- Sample-point timing is identical in both builds.

## Structure
- Package `rx_serial_pkg` holds:
  - state codes (4-bit constants)
  - `DIV`/`HALF` defaults
  - frame length constant (7 data bits)
- Sub-module `contador_m`: loadable down-counter with expiry pulse, driving `db_tick`.

## Test plan
- Send 35h, parity 0, stop 1 → `dados_ascii`=35h, `erro_paridade`=0, `erro_framing`=0, `pronto` pulse at 49479 clocks, `tem_dado`=1.
- Send 7Fh with parity bit 0 (correct is 1) → `dados_ascii`=7Fh, `erro_paridade`=1.
- Send 55h with stop bit 0, line held low for 2 bit times → `erro_framing`=1, `db_estado`=6 until the line returns high, exactly one `pronto`.
- 1000-clock low glitch on the idle line → `db_estado` returns to 0, no `pronto`, `tem_dado` unchanged.
- Handshake:
  - Receive 7Eh, then pulse `recebe_dado` → `tem_dado`=0 next cycle.
  - Receive 35h then 55h with no acknowledge → `dados_ascii`=55h, `tem_dado`=1.
- Assert `reset`=0 during the 4th data bit → all outputs at reset values immediately; the next clean frame (55h) is received correctly.
